// File: rtl/mod_addsub_acc.sv
// -----------------------------------------------------------------------------
// mod_addsub_acc
//
// Multi-lane, two-stage pipelined modular add / subtract / accumulate unit.
// Every lane works on residues modulo a runtime modulus. All lanes share the
// modulus and the operation mode of a beat.
//
//   Stage 1 : input register. Holds valid, mode, both operand vectors and
//             the modulus of one beat.
//   Stage 2 : compute register. Holds oData / oErr / oValid and the per-lane
//             accumulators.
//
// Modes (iMode):
//   2'b00  add      result = (d0 + d1)  mod m
//   2'b01  sub      result = (d0 - d1)  mod m
//   2'b10  acc-add  result = (acc + d0) mod m, acc <= result
//   2'b11  acc-sub  result = (acc - d0) mod m, acc <= result
//
// A lane reports an error when the modulus is zero or any operand it uses is
// not already reduced (>= m). An erroring lane outputs 0 and keeps its
// accumulator. The other lanes are not affected.
//
// Parameters:
//   BITWIDTH  width of each operand, the modulus and each lane result
//   LANES     number of independent lanes per beat
//
// Ports:
//   iClk    clock; all state changes on the rising edge
//   iRst    synchronous active-high reset; clears every register
//   iEn     pipeline enable; low holds the pipeline and the accumulators
//   iClr    synchronous clear of accumulators and pipeline valids
//           (applies even when iEn is low)
//   iValid  input beat valid, sampled only when iEn = 1
//   iMode   operation mode of the beat (see above)
//   iData0  operand 0, lane k at [k*BITWIDTH +: BITWIDTH]
//   iData1  operand 1, same packing; ignored in the accumulate modes
//   iMod    modulus for the beat, shared by all lanes
//   oValid  output beat valid
//   oData   per-lane result, same packing as the inputs
//   oErr    per-lane error flag for the current output beat
// -----------------------------------------------------------------------------
module mod_addsub_acc #(
    parameter int BITWIDTH = 32,
    parameter int LANES    = 4
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic                      iEn,
    input  logic                      iClr,
    input  logic                      iValid,
    input  logic [1:0]                iMode,
    input  logic [LANES*BITWIDTH-1:0] iData0,
    input  logic [LANES*BITWIDTH-1:0] iData1,
    input  logic [BITWIDTH-1:0]       iMod,
    output logic                      oValid,
    output logic [LANES*BITWIDTH-1:0] oData,
    output logic [LANES-1:0]          oErr
);

    // -------------------------------------------------------------------------
    // Stage 1: input register
    // -------------------------------------------------------------------------
    logic                      s1ValidReg;
    logic [1:0]                s1ModeReg;
    logic [LANES*BITWIDTH-1:0] s1Data0Reg;
    logic [LANES*BITWIDTH-1:0] s1Data1Reg;
    logic [BITWIDTH-1:0]       s1ModReg;

    // A clear drops the beat presented in the same cycle. Only the valid bit
    // has to be cleared for that, because the payload is ignored while the
    // valid bit is low.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            s1ValidReg <= 1'b0;
            s1ModeReg  <= '0;
            s1Data0Reg <= '0;
            s1Data1Reg <= '0;
            s1ModReg   <= '0;
        end else if (iClr) begin
            s1ValidReg <= 1'b0;
        end else if (iEn) begin
            s1ValidReg <= iValid;
            s1ModeReg  <= iMode;
            s1Data0Reg <= iData0;
            s1Data1Reg <= iData1;
            s1ModReg   <= iMod;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2 datapath (combinational, per lane)
    // -------------------------------------------------------------------------
    // Mode bit 1 selects the accumulator as the first operand.
    // Mode bit 0 selects subtraction.
    logic accMode;
    logic subMode;
    logic modZero;

    assign accMode = s1ModeReg[1];
    assign subMode = s1ModeReg[0];
    assign modZero = (s1ModReg == '0);

    logic [LANES-1:0][BITWIDTH-1:0] accReg;
    logic [LANES-1:0][BITWIDTH-1:0] accNext;
    logic [LANES*BITWIDTH-1:0]      resultVec;
    logic [LANES-1:0]               errVec;

    for (genvar gi = 0; gi < LANES; gi++) begin : gLane
        logic [BITWIDTH-1:0] d0Lane;
        logic [BITWIDTH-1:0] d1Lane;
        logic [BITWIDTH-1:0] opA;
        logic [BITWIDTH-1:0] opB;
        logic [BITWIDTH:0]   modWide;
        logic [BITWIDTH:0]   sumWide;
        logic [BITWIDTH-1:0] addRes;
        logic [BITWIDTH-1:0] subRes;
        logic                laneErr;
        logic [BITWIDTH-1:0] laneRes;

        assign d0Lane = s1Data0Reg[gi*BITWIDTH +: BITWIDTH];
        assign d1Lane = s1Data1Reg[gi*BITWIDTH +: BITWIDTH];

        // In the accumulate modes, d0 becomes the second operand and d1 is
        // not used.
        assign opA = accMode ? accReg[gi] : d0Lane;
        assign opB = accMode ? d0Lane     : d1Lane;

        // d0 is checked in every mode. In the plain modes, d1 is checked.
        // In the accumulate modes, the accumulator is checked instead; it can
        // be out of range after a later beat brings a smaller modulus.
        assign laneErr = modZero
                       || (d0Lane >= s1ModReg)
                       || (!accMode && (d1Lane >= s1ModReg))
                       || ( accMode && (accReg[gi] >= s1ModReg));

        // The sum needs one extra bit: with m close to 2^BITWIDTH, a + b can
        // carry out before reduction.
        assign modWide = {1'b0, s1ModReg};
        assign sumWide = {1'b0, opA} + {1'b0, opB};
        assign addRes  = (sumWide >= modWide) ? BITWIDTH'(sumWide - modWide)
                                              : sumWide[BITWIDTH-1:0];

        // When a < b, the true value a - b + m lies in [0, m). Any wrap in the
        // intermediate BITWIDTH-bit arithmetic therefore cancels out, and the
        // truncated result is exact.
        assign subRes = (opA >= opB) ? (opA - opB)
                                     : (opA - opB + s1ModReg);

        assign laneRes = laneErr ? '0 : (subMode ? subRes : addRes);

        assign resultVec[gi*BITWIDTH +: BITWIDTH] = laneRes;
        assign errVec[gi] = laneErr;

        // The accumulator follows the lane result only for valid,
        // error-free accumulate beats.
        assign accNext[gi] = (s1ValidReg && accMode && !laneErr) ? laneRes
                                                                 : accReg[gi];
    end

    // -------------------------------------------------------------------------
    // Stage 2: compute register and accumulators
    // -------------------------------------------------------------------------
    // The accumulators load in the same edge as oData. The next acc beat sees
    // the updated value straight from accReg, so back-to-back accumulate beats
    // need no forwarding.
    // A bubble in stage 1 only drops oValid. oData and oErr keep the last beat.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            accReg <= '0;
            oValid <= 1'b0;
            oData  <= '0;
            oErr   <= '0;
        end else if (iClr) begin
            accReg <= '0;
            oValid <= 1'b0;
        end else if (iEn) begin
            if (s1ValidReg) begin
                oValid <= 1'b1;
                oData  <= resultVec;
                oErr   <= errVec;
                accReg <= accNext;
            end else begin
                oValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mod_addsub_acc.sv
`timescale 1ns/1ps
module tb_mod_addsub_acc;

    localparam int BW = 32;
    localparam int LN = 4;

    typedef logic [LN-1:0][BW-1:0] lanes_t;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] m;
        lanes_t      d0;
        lanes_t      d1;
        lanes_t      expData;
        logic [3:0]  expErr;
    } vec_t;

    logic          iClk = 1'b0;
    logic          iRst;
    logic          iEn;
    logic          iClr;
    logic          iValid;
    logic [1:0]    iMode;
    lanes_t        iData0;
    lanes_t        iData1;
    logic [BW-1:0] iMod;
    logic          oValid;
    logic [LN*BW-1:0] oData;
    logic [LN-1:0] oErr;

    mod_addsub_acc #(.BITWIDTH(BW), .LANES(LN)) dut (
        .iClk   (iClk),
        .iRst   (iRst),
        .iEn    (iEn),
        .iClr   (iClr),
        .iValid (iValid),
        .iMode  (iMode),
        .iData0 (iData0),
        .iData1 (iData1),
        .iMod   (iMod),
        .oValid (oValid),
        .oData  (oData),
        .oErr   (oErr)
    );

    always #5 iClk = ~iClk;

    int checks = 0;
    int passed = 0;

    function automatic lanes_t mk(input logic [31:0] l0, input logic [31:0] l1,
                                  input logic [31:0] l2, input logic [31:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic check(input string name, input logic expV, input lanes_t expD,
                         input logic [3:0] expE);
        checks++;
        if (oValid === expV && oData === expD && oErr === expE) begin
            passed++;
            $display("ok   %s valid=%0b data=%h err=%b", name, oValid, oData, oErr);
        end else begin
            $display("FAIL %s got valid=%0b data=%h err=%b want valid=%0b data=%h err=%b",
                     name, oValid, oData, oErr, expV, expD, expE);
        end
    endtask

    task automatic drive(input logic [1:0] mode, input logic [31:0] m,
                         input lanes_t d0, input lanes_t d1);
        iValid = 1'b1;
        iMode  = mode;
        iMod   = m;
        iData0 = d0;
        iData1 = d1;
    endtask

    vec_t vecs[8];

    // Reference model state for the random stream
    int unsigned mAcc[LN];
    lanes_t q;
    logic   mdlV;
    lanes_t mdlD;
    logic   s1P;
    lanes_t s1D;
    logic   newP;
    lanes_t newD;
    lanes_t rd0, rd1, preClr;

    initial begin
        // ---------------- vector table (modes 00/01, stateless) -------------
        vecs[0] = '{2'b00, 32'd23, mk(20,3,0,22), mk(5,7,0,22), mk(2,10,0,21), 4'b0000};
        vecs[1] = '{2'b01, 32'd23, mk(20,3,0,22), mk(5,7,0,22), mk(15,19,0,0), 4'b0000};
        vecs[2] = '{2'b00, 32'hFFFF_FFFF,
                    mk(32'hFFFF_FFFE,32'hFFFF_FFFE,32'hFFFF_FFFE,32'hFFFF_FFFE),
                    mk(32'hFFFF_FFFE,32'hFFFF_FFFE,32'hFFFF_FFFE,32'hFFFF_FFFE),
                    mk(32'hFFFF_FFFD,32'hFFFF_FFFD,32'hFFFF_FFFD,32'hFFFF_FFFD), 4'b0000};
        vecs[3] = '{2'b01, 32'hFFFF_FFFF, mk(0,0,0,0), mk(1,1,1,1),
                    mk(32'hFFFF_FFFE,32'hFFFF_FFFE,32'hFFFF_FFFE,32'hFFFF_FFFE), 4'b0000};
        vecs[4] = '{2'b00, 32'd23, mk(20,23,0,22), mk(5,7,0,22), mk(2,0,0,21), 4'b0010};
        vecs[5] = '{2'b01, 32'd0, mk(0,1,2,3), mk(0,0,0,0), mk(0,0,0,0), 4'b1111};
        vecs[6] = '{2'b01, 32'd23, mk(1,2,3,4), mk(1,5,3,30), mk(0,20,0,0), 4'b1000};
        vecs[7] = '{2'b00, 32'd23, mk(10,0,22,1), mk(13,0,1,21), mk(0,0,0,22), 4'b0000};

        // ---------------- reset ---------------------------------------------
        iRst = 1'b1; iEn = 1'b1; iClr = 1'b0;
        drive(vecs[0].mode, vecs[0].m, vecs[0].d0, vecs[0].d1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_hold", 1'b0, '0, 4'b0000);
        end
        iRst = 1'b0;
        step();
        check("reset_lat1", 1'b0, '0, 4'b0000);
        iValid = 1'b0;
        step();
        check("reset_lat2", 1'b1, vecs[0].expData, vecs[0].expErr);

        // ---------------- table-driven vectors ------------------------------
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].mode, vecs[i].m, vecs[i].d0, vecs[i].d1);
            step();
            iValid = 1'b0;
            step();
            check($sformatf("vec%0d", i), 1'b1, vecs[i].expData, vecs[i].expErr);
        end

        // ---------------- accumulate, back-to-back --------------------------
        rd1 = mk(99,99,99,99);      // d1 must be ignored in acc modes
        drive(2'b10, 32'd23, mk(10,0,0,0), rd1); step();
        drive(2'b10, 32'd23, mk(15,0,0,0), rd1); step();
        check("acc_10", 1'b1, mk(10,0,0,0), 4'b0000);
        drive(2'b10, 32'd23, mk(22,0,0,0), rd1); step();
        check("acc_2", 1'b1, mk(2,0,0,0), 4'b0000);
        drive(2'b11, 32'd23, mk(5,0,0,0), rd1); step();
        check("acc_1", 1'b1, mk(1,0,0,0), 4'b0000);
        iValid = 1'b0; step();
        check("accsub_19", 1'b1, mk(19,0,0,0), 4'b0000);
        iClr = 1'b1; step();
        check("clr_en1", 1'b0, mk(19,0,0,0), 4'b0000);
        iClr = 1'b0;
        drive(2'b10, 32'd23, mk(4,0,0,0), rd1); step();
        iValid = 1'b0; step();
        check("acc_after_clr", 1'b1, mk(4,0,0,0), 4'b0000);

        // ---------------- accumulator out of range after modulus shrink -----
        drive(2'b10, 32'd23, mk(16,0,0,0), rd1); step();
        drive(2'b10, 32'd11, mk(1,0,0,0), rd1); step();
        check("acc_20", 1'b1, mk(20,0,0,0), 4'b0000);
        drive(2'b10, 32'd23, mk(0,0,0,0), rd1); step();
        check("acc_err_m11", 1'b1, mk(0,0,0,0), 4'b0001);
        iValid = 1'b0; step();
        check("acc_kept_20", 1'b1, mk(20,0,0,0), 4'b0000);

        // ---------------- random stream with a 5-cycle stall ----------------
        mAcc[0] = 20; mAcc[1] = 0; mAcc[2] = 0; mAcc[3] = 0;
        s1P = 1'b0; mdlV = 1'b0; mdlD = mk(20,0,0,0); s1D = '0;
        begin
            int sent, got, cyc;
            sent = 0; got = 0; cyc = 0;
            while (got < 100 && cyc < 1000) begin
                logic en;
                en = !(cyc >= 40 && cyc < 45);
                iEn = en;
                newP = 1'b0; newD = '0;
                if (en && sent < 100 && $urandom_range(0, 4) != 0) begin
                    logic [1:0] md;
                    md = 2'($urandom_range(0, 3));
                    for (int k = 0; k < LN; k++) begin
                        int unsigned a, b, r;
                        rd0[k] = $urandom_range(0, 22);
                        rd1[k] = md[1] ? $urandom_range(0, 200) : $urandom_range(0, 22);
                        a = md[1] ? mAcc[k] : rd0[k];
                        b = md[1] ? rd0[k] : rd1[k];
                        r = md[0] ? (a + 23 - b) % 23 : (a + b) % 23;
                        if (md[1]) mAcc[k] = r;
                        newD[k] = r;
                    end
                    drive(md, 32'd23, rd0, rd1);
                    newP = 1'b1;
                    sent++;
                end else begin
                    // junk that must never be captured
                    for (int k = 0; k < LN; k++) begin
                        rd0[k] = $urandom;
                        rd1[k] = $urandom;
                    end
                    drive(2'($urandom_range(0, 3)), $urandom, rd0, rd1);
                    iValid = !en;
                end
                step();
                if (en) begin
                    if (s1P) begin
                        mdlV = 1'b1;
                        mdlD = s1D;
                        got++;
                    end else begin
                        mdlV = 1'b0;
                    end
                    s1P = newP;
                    s1D = newD;
                end
                check(en ? "rand" : "stall", mdlV, mdlD, 4'b0000);
                cyc++;
            end
            if (got < 100) begin
                checks++;
                $display("FAIL rand_budget got beats=%0d want 100", got);
            end
        end

        // ---------------- clear while stalled -------------------------------
        iEn = 1'b1;
        iValid = 1'b0;
        step();
        rd0 = mk(1,2,3,4);
        for (int k = 0; k < LN; k++) begin
            mAcc[k] = (mAcc[k] + rd0[k]) % 23;
            preClr[k] = mAcc[k];
        end
        drive(2'b10, 32'd23, rd0, '0); step();
        iValid = 1'b0; step();
        check("acc_pre_clr", 1'b1, preClr, 4'b0000);
        iEn = 1'b0; iClr = 1'b1;
        step();
        check("clr_en0", 1'b0, preClr, 4'b0000);
        iClr = 1'b0; iEn = 1'b1;
        drive(2'b10, 32'd23, mk(0,0,0,0), '0); step();
        iValid = 1'b0; step();
        check("acc_zero_after_clr", 1'b1, mk(0,0,0,0), 4'b0000);

        // ---------------- reset mid-stream ----------------------------------
        drive(2'b10, 32'd23, mk(7,0,0,0), '0); step();
        iValid = 1'b0; step();
        check("acc_7", 1'b1, mk(7,0,0,0), 4'b0000);
        drive(2'b00, 32'd23, mk(1,1,1,1), mk(1,1,1,1)); step();
        iRst = 1'b1; step();
        check("rst_mid", 1'b0, '0, 4'b0000);
        iRst = 1'b0;
        drive(2'b10, 32'd23, mk(0,0,0,0), '0); step();
        check("rst_mid_drop", 1'b0, '0, 4'b0000);
        iValid = 1'b0; step();
        check("rst_acc_zero", 1'b1, mk(0,0,0,0), 4'b0000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
